// File: rtl/seq_signed_or_unsigned_mul.sv
// Multi-cycle radix-2 shift-add multiplier with signed/unsigned selection and valid/ready handshakes.
// Define SEQ_MUL_EARLY_EXIT_EN to end iteration once the remaining multiplier magnitude is zero.
module seq_signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_valid,
  output logic           up_ready,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic           down_valid,
  input  logic           down_ready,
  output logic [2*n-1:0] res
);

  localparam int cw = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [n-1:0]    mcand;
  logic [n-1:0]    mplier;
  logic [2*n-1:0]  acc;
  logic [cw-1:0]   cnt;
  logic            neg;

  logic [n-1:0]    a_mag;
  logic [n-1:0]    b_mag;
  logic [2*n-1:0]  acc_next;
  logic            last_iter;

  // The most negative operand negates to itself, which is exactly its n-bit unsigned magnitude.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    a_mag    = a;
    b_mag    = b;
    acc_next = acc;
    if (signed_mul && a[n-1]) a_mag = -a;
    if (signed_mul && b[n-1]) b_mag = -b;
    if (mplier[0]) acc_next = acc + ({{n{1'b0}}, mcand} << cnt);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    last_iter = (mplier[n-1:1] == '0);
`else
    last_iter = (cnt == cw'(n - 1));
`endif
  end

  assign up_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (!rst_n) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      down_valid <= 1'b0;
      res        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mul && (a[n-1] ^ b[n-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + cw'(1);
          if (last_iter) begin
            // A zero product with sign 1 negates to zero, so no special case is needed.
            res        <= neg ? -acc_next : acc_next;
            down_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (down_ready) begin
            down_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// Self-checking bench for seq_signed_or_unsigned_mul (n=8): vector table, scoreboard, and
// hand-written backpressure and reset-abort sequences.
module tb_seq_signed_or_unsigned_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_valid;
  logic        up_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_mul;
  logic        down_valid;
  logic        down_ready;
  logic [15:0] res;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] res;
  } vec_t;

  exp_t sb_q[$];

  seq_signed_or_unsigned_mul #(.n(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .a          (a),
    .b          (b),
    .signed_mul (signed_mul),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .res        (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] p;
    if (s) p = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
    else   p = {8'h00, x} * {8'h00, y};
    return p;
  endfunction

  function automatic int exp_lat(input logic [7:0] y, input logic s);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic [7:0] m;
    int l;
    m = (s && y[7]) ? -y : y;
    l = 1;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Accept one operand bundle and record what the consumer must eventually see.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] r);
    exp_t e;
    int w = 0;
    while (!up_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("up_ready_wait", {31'd0, up_ready}, 32'd1);
    a = x; b = y; signed_mul = s; up_valid = 1'b1;
    @(posedge clk); #1;
    up_valid = 1'b0;
    a = ~x; b = ~y; signed_mul = ~s;
    e.res = r;
    e.lat = exp_lat(y, s);
    sb_q.push_back(e);
  endtask

  task automatic await_result(input string name);
    exp_t e;
    int lat = 0;
    while (!down_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_sb_depth"}, sb_q.size(), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({name, "_latency"}, lat, e.lat);
      check({name, "_down_valid"}, {31'd0, down_valid}, 32'd1);
      check({name, "_res"}, {16'd0, res}, {16'd0, e.res});
    end
  endtask

  // With down_ready high the handshake completes at the next edge and IDLE follows.
  task automatic handshake(input string name);
    @(posedge clk); #1;
    check({name, "_dv_cleared"}, {31'd0, down_valid}, 32'd0);
    check({name, "_idle_ready"}, {31'd0, up_ready}, 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[4]  = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    vecs[5]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
    vecs[6]  = '{8'h80, 8'h00, 1'b0, 16'h0000};
    vecs[7]  = '{8'hFD, 8'h03, 1'b1, 16'hFFF7};
    vecs[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[9]  = '{8'h05, 8'h01, 1'b0, 16'h0005};
    vecs[10] = '{8'h05, 8'h00, 1'b0, 16'h0000};
    vecs[11] = '{8'h03, 8'h40, 1'b0, 16'h00C0};
    vecs[12] = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    vecs[13] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

    rst_n = 1'b0; up_valid = 1'b0; a = '0; b = '0; signed_mul = 1'b0; down_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_down_valid", {31'd0, down_valid}, 32'd0);
    check("rst_res", {16'd0, res}, 32'd0);
    check("rst_up_ready", {31'd0, up_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_up_ready", {31'd0, up_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res);
      await_result($sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      send(x, y, s, model(x, y, s));
      await_result($sformatf("rnd%0d", i));
      handshake($sformatf("rnd%0d", i));
    end

    // Backpressure: the result must hold and stray up_valid pulses must not start work.
    down_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 16'h03A8);
    await_result("bp");
    for (int i = 0; i < 5; i++) begin
      up_valid = (i % 2 == 0); a = 8'h11; b = 8'h22; signed_mul = 1'b0;
      @(posedge clk); #1;
      check($sformatf("bp_hold_dv%0d", i), {31'd0, down_valid}, 32'd1);
      check($sformatf("bp_hold_res%0d", i), {16'd0, res}, 32'h03A8);
      check($sformatf("bp_hold_ready%0d", i), {31'd0, up_ready}, 32'd0);
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    handshake("bp");
    send(8'h03, 8'h04, 1'b0, 16'h000C);
    await_result("bp_next");
    handshake("bp_next");

    // Reset during the third BUSY cycle aborts the product.
    send(8'h05, 8'h07, 1'b0, 16'h0023);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_down_valid", {31'd0, down_valid}, 32'd0);
    check("abort_res", {16'd0, res}, 32'd0);
    check("abort_up_ready", {31'd0, up_ready}, 32'd0);
    void'(sb_q.pop_front());
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (down_valid) seen = 1'b1;
      end
      check("abort_no_result", {31'd0, seen}, 32'd0);
    end
    send(8'hFD, 8'h03, 1'b1, 16'hFFF7);
    await_result("after_abort");
    handshake("after_abort");

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_signed_or_unsigned_mul.md
# seq_signed_or_unsigned_mul

Parameterised multi-cycle N×N multiplier producing a 2N-bit signed or unsigned product, selected per operation by `signed_mul`. It uses one radix-2 shift-add iteration per clock, trading latency for area. Operands enter through a valid/ready upstream handshake and results leave through a valid/ready downstream handshake. It replaces the combinational multiplier wherever a full N×N array does not fit the cycle budget.

## Interface
- `n`, default 8: operand width in bits; must be ≥ 2.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `up_valid` input 1: the operand bundle is valid.
- `up_ready` output 1: the block can accept operands.
- `a` input n: multiplicand.
- `b` input n: multiplier.
- `signed_mul` input 1: 1 selects two's-complement operands and result; 0 selects unsigned.
- `down_valid` output 1: `res` holds a completed product.
- `down_ready` input 1: the consumer accepts `res`.
- `res` output 2n: the product.

## Operation
- States:
  - IDLE: `up_ready`=1.
  - BUSY: iterating; `up_ready`=0, `down_valid`=0.
  - DONE: `down_valid`=1, `up_ready`=0.
- IDLE→BUSY on `up_valid && up_ready`.
  - Capture `signed_mul` and the operand magnitudes. In signed mode the magnitude is |a| and |b| as n-bit unsigned, and the result sign is `a[n-1]^b[n-1]`. In unsigned mode the magnitudes are a and b, and the sign is 0.
  - Clear the 2n-bit accumulator and the iteration counter.
- BUSY, each cycle:
  - If the multiplier LSB is 1, the accumulator += the multiplicand shifted left by the counter.
  - Shift the multiplier right by 1 and increment the counter.
- BUSY→DONE after the final iteration.
  - `res` is the accumulator, two's-complement negated in the same edge if the sign is 1.
- DONE→IDLE on `down_ready`. No new operand is accepted in that same cycle.
- In DONE, while `down_ready`=0, `res` and `down_valid` hold stable.
- `a`, `b` and `signed_mul` are sampled only at acceptance. Later changes are ignored.
- `up_valid` in BUSY or DONE is ignored and not queued.
- Width rules:
  - The magnitude of the most negative value (e.g. 0x80 for n=8) is 2^(n-1) and fits the n-bit magnitude register.
  - The signed result range is −2^(2n-2)+2^(n-1) .. 2^(2n-2). It always fits 2n bits.
  - No overflow or saturation logic is required.
- A zero operand in signed mode with sign 1 negates 0 to 0; `res` must be 0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State → IDLE.
  - `down_valid`=0.
  - `res`=0.
  - Accumulator, counter and captured operands are cleared.
  - `up_ready` is forced to 0 while `rst_n`=0 and is 1 from the first cycle after release.
- Reset mid-BUSY or mid-DONE aborts the operation; its result is never presented.
- Latency, with operands accepted at edge E0:
  - Iterations occupy edges E1..En.
  - `down_valid` is high after edge En, giving latency n cycles.
- The earliest next acceptance is the cycle after the `down_ready` handshake. Throughput is one product per n+2 cycles with `down_ready` tied high.
- `res` changes only at the BUSY→DONE edge and on reset.

## Configuration
- `SEQ_MUL_EARLY_EXIT_EN`
  - Defined: BUSY ends after the iteration in which the shifted multiplier magnitude becomes zero. Latency is max(1, index of the highest set bit of the multiplier magnitude + 1) cycles; a zero multiplier takes 1 cycle. Results are identical to the fixed-latency build.
  - Undefined: latency is always exactly n cycles.

## Test plan
- n=8, unsigned, a=0xFF, b=0xFF, `down_ready`=1 → `res`=0xFE01, with `down_valid` exactly 8 cycles after acceptance (macro undefined).
- Signed cases:
  - a=0x80, b=0x80 → 0x4000.
  - a=0xFF, b=0x01 → 0xFFFF.
  - a=0x80, b=0x7F → 0xC080.
  - The same a=0x80, b=0x7F unsigned → 0x3F80.
- Backpressure: complete 0x12×0x34 (unsigned, expect 0x03A8) with `down_ready`=0 for 5 cycles. `down_valid`=1, `res` stays 0x03A8 and `up_ready`=0 throughout. `up_valid` pulses during the stall are not executed. After `down_ready`, IDLE is reached and the next operand is accepted.
- Reset in the 3rd BUSY cycle of 0x05×0x07 → `down_valid`=0 and `res`=0 after the edge. A following signed 0xFD×0x03 gives `res`=0xFFF7.
- Zero handling: signed a=0x00, b=0x80 → `res`=0x0000. Unsigned a=0x80, b=0x00 → 0x0000.
- Macro defined:
  - b=0x01 → latency 1.
  - b=0x00 → latency 1.
  - b=0x40 → latency 7.
  - Signed b=0x80 (magnitude 0x80) → latency 8.
  - All products match the fixed-latency build.
